// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the frame-assembler state encoding and the parity helper used when a frame completes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam logic        LINE_IDLE     = 1'b1;
  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 8;

  // True when data bits plus the received parity bit do not XOR to the expected sense.
  function automatic logic parity_bad(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     par_bit,
                                      input logic                     odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/rx_out_buffer.sv
// Single-entry valid/ready holding register for received characters.
// A load that arrives while an unconsumed character is held is dropped and flagged by a one-cycle overrun pulse.
module rx_out_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ferr_i,
  input  logic             perr_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             ferr_o,
  output logic             perr_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;
  logic             can_accept;

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    ovr_d      = 1'b0;
    // A consume in the same cycle frees the slot for the incoming character.
    can_accept = !valid_q || ready_i;
    if (load_i) begin
      if (can_accept) begin
        data_d  = data_i;
        ferr_d  = ferr_i;
        perr_d  = perr_i;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign ferr_o    = ferr_q;
  assign perr_o    = perr_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// UART receive frame assembler: validates the start bit, shifts data LSB first on mid-bit strobes,
// checks optional parity and the stop bit, and hands each character to a valid/ready buffer.
module uart_rx_frame_assembler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_stb,
  input  logic                 serial_in,
  output logic                 rx_busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned          CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(DATA_BITS - 1);
  localparam logic                 ODD_SENSE = (PARITY_ODD != 0);

  rx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 par_q, par_d;

  logic                 frame_done;
  logic                 frame_ferr;
  logic                 frame_perr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  // Next-state logic; nothing moves without a sample strobe.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    if (sample_stb) begin
      unique case (state_q)
        IDLE: begin
          if (serial_in != LINE_IDLE) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {serial_in, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_d   = serial_in;
          state_d = STOP;
        end
        STOP: begin
          // A low stop bit may be the start of a break; wait for the line to recover.
          state_d = (serial_in == LINE_IDLE) ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (serial_in == LINE_IDLE) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs of the state machine
  always_comb begin
    rx_busy    = (state_q != IDLE);
    frame_done = sample_stb && (state_q == STOP);
    frame_ferr = (serial_in != LINE_IDLE);
    frame_perr = (PARITY_EN != 0) ?
                 parity_bad(MAX_DATA_BITS'(shift_q), par_q, ODD_SENSE) : 1'b0;
  end

  rx_out_buffer #(
    .WIDTH(DATA_BITS)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (frame_done),
    .data_i   (shift_q),
    .ferr_i   (frame_ferr),
    .perr_i   (frame_perr),
    .ready_i  (data_ready),
    .data_o   (data_out),
    .valid_o  (data_valid),
    .ferr_o   (framing_err),
    .perr_o   (parity_err),
    .overrun_o(overrun)
  );

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Bench for uart_rx_frame_assembler: an 8N1 instance and an 8-bit even-parity instance,
// driven with directed frames then random traffic, compared every cycle against a frame-level model.
module tb_uart_rx_frame_assembler;

  logic       clk;
  logic       rst;
  logic [1:0] stb, ser, rdy;
  logic [1:0] busy, dv, fe, pe, ov;
  logic [7:0] dout0, dout1;

  int checks = 0;
  int errors = 0;

  // Frame-level model state per instance
  logic [7:0] m_data [2];
  logic [7:0] cd [2];
  logic [1:0] m_valid, m_fe, m_pe, m_ov, m_busy, nb, comp, cf, cp;
  bit         rand_rdy;

  uart_rx_frame_assembler #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .sample_stb(stb[0]), .serial_in(ser[0]), .rx_busy(busy[0]),
    .data_out(dout0), .data_valid(dv[0]), .data_ready(rdy[0]), .framing_err(fe[0]),
    .parity_err(pe[0]), .overrun(ov[0])
  );

  uart_rx_frame_assembler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .sample_stb(stb[1]), .serial_in(ser[1]), .rx_busy(busy[1]),
    .data_out(dout1), .data_valid(dv[1]), .data_ready(rdy[1]), .framing_err(fe[1]),
    .parity_err(pe[1]), .overrun(ov[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; update the model from inputs seen at the edge, then compare all outputs.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_valid[i] = 1'b0; m_data[i] = 8'h00; m_fe[i] = 1'b0; m_pe[i] = 1'b0;
        m_ov[i] = 1'b0; m_busy[i] = 1'b0; nb[i] = 1'b0;
      end else begin
        m_ov[i] = 1'b0;
        if (comp[i]) begin
          if (!m_valid[i] || rdy[i]) begin
            m_data[i] = cd[i]; m_fe[i] = cf[i]; m_pe[i] = cp[i]; m_valid[i] = 1'b1;
          end else begin
            m_ov[i] = 1'b1;
          end
        end else if (m_valid[i] && rdy[i]) begin
          m_valid[i] = 1'b0;
        end
        m_busy[i] = nb[i];
      end
      comp[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("data_out%0d", i), (i == 0) ? dout0 : dout1, m_data[i]);
      chk($sformatf("data_valid%0d", i), dv[i], m_valid[i]);
      chk($sformatf("framing_err%0d", i), fe[i], m_fe[i]);
      chk($sformatf("parity_err%0d", i), pe[i], m_pe[i]);
      chk($sformatf("overrun%0d", i), ov[i], m_ov[i]);
      chk($sformatf("rx_busy%0d", i), busy[i], m_busy[i]);
    end
    stb = 2'b00;
    if (rand_rdy) rdy = 2'($urandom);
  endtask

  task automatic strobe(input int i, input logic b, input logic busy_after);
    stb[i] = 1'b1;
    ser[i] = b;
    nb[i]  = busy_after;
    tick();
    ser[i] = 1'b1;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // stop_rdy < 0 leaves data_ready alone on the stop strobe cycle.
  task automatic send_frame(input int i, input logic [7:0] data, input logic pbit,
                            input logic stopb, input int stop_rdy);
    logic saved;
    strobe(i, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) strobe(i, data[k], 1'b1);
    if (i == 1) strobe(i, pbit, 1'b1);
    saved    = rdy[i];
    stb[i]   = 1'b1;
    ser[i]   = stopb;
    nb[i]    = !stopb;
    comp[i]  = 1'b1;
    cd[i]    = data;
    cf[i]    = !stopb;
    cp[i]    = (i == 1) ? (((^data) ^ pbit) != 1'b0) : 1'b0;
    if (stop_rdy >= 0) rdy[i] = (stop_rdy != 0);
    tick();
    ser[i] = 1'b1;
    if (stop_rdy >= 0) rdy[i] = saved;
  endtask

  task automatic consume(input int i);
    rdy[i] = 1'b1;
    tick();
    rdy[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stb = 2'b00; ser = 2'b11; rdy = 2'b00;
    m_valid = '0; m_fe = '0; m_pe = '0; m_ov = '0; m_busy = '0; nb = '0; comp = '0;
    cf = '0; cp = '0; rand_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin m_data[i] = 8'h00; cd[i] = 8'h00; end

    tick(); tick();
    rst = 1'b1;
    tick();
    chk("reset_valid", dv[0], 1'b0);
    chk("reset_data", dout0, 8'h00);

    // 8N1 frame 0xA5
    send_frame(0, 8'hA5, 1'b0, 1'b1, -1);
    chk("a5_data", dout0, 8'hA5);
    chk("a5_valid", dv[0], 1'b1);
    chk("a5_ferr", fe[0], 1'b0);
    chk("a5_busy", busy[0], 1'b0);
    consume(0);
    chk("a5_consumed", dv[0], 1'b0);

    // Glitch starts are ignored
    strobe(0, 1'b1, 1'b0);
    strobe(0, 1'b1, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b1, -1);
    chk("glitch_data", dout0, 8'h3C);
    consume(0);

    // Bad stop bit followed by a held-low line
    send_frame(0, 8'hFF, 1'b0, 1'b0, -1);
    chk("break_data", dout0, 8'hFF);
    chk("break_ferr", fe[0], 1'b1);
    chk("break_busy", busy[0], 1'b1);
    repeat (3) strobe(0, 1'b0, 1'b1);
    chk("break_hold_busy", busy[0], 1'b1);
    chk("break_hold_data", dout0, 8'hFF);
    strobe(0, 1'b1, 1'b0);
    chk("break_idle", busy[0], 1'b0);
    consume(0);
    send_frame(0, 8'h81, 1'b0, 1'b1, -1);
    chk("after_break_data", dout0, 8'h81);
    chk("after_break_ferr", fe[0], 1'b0);
    consume(0);

    // Overrun: second character dropped
    send_frame(0, 8'h11, 1'b0, 1'b1, -1);
    send_frame(0, 8'h22, 1'b0, 1'b1, -1);
    chk("ovr_pulse", ov[0], 1'b1);
    chk("ovr_keep", dout0, 8'h11);
    tick();
    chk("ovr_one_cycle", ov[0], 1'b0);
    consume(0);
    // Same pair, consumed on the completion cycle: no overrun
    send_frame(0, 8'h11, 1'b0, 1'b1, -1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1);
    chk("pass_data", dout0, 8'h22);
    chk("pass_valid", dv[0], 1'b1);
    chk("pass_no_ovr", ov[0], 1'b0);
    consume(0);

    // Even parity on 0x07
    send_frame(1, 8'h07, 1'b0, 1'b1, -1);
    chk("par0_err", pe[1], 1'b1);
    chk("par0_data", dout1, 8'h07);
    consume(1);
    send_frame(1, 8'h07, 1'b1, 1'b1, -1);
    chk("par1_err", pe[1], 1'b0);
    consume(1);

    // Reset in the middle of a frame
    strobe(0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) strobe(0, k[0], 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_valid", dv[0], 1'b0);
    chk("midrst_data", dout0, 8'h00);
    send_frame(0, 8'h5A, 1'b0, 1'b1, -1);
    chk("post_rst_data", dout0, 8'h5A);
    consume(0);

    // Random traffic with random consumer backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int         i;
      logic [7:0] d;
      logic       pb, sb;
      i  = int'($urandom_range(0, 1));
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) strobe(i, 1'b1, 1'b0);
      send_frame(i, d, pb, sb, -1);
      if (!sb) strobe(i, 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_rdy = 1'b0;
    rdy = 2'b11;
    tick();
    rdy = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
